sc_mnist_inference_ctrl: RTL

Sequencing controller for the two-layer stochastic-computing MNIST digit network. On `start` it resets the network's neuron state, lets the bitstream pipeline fill, and accumulates each of the N2 output bitstreams over a fixed window of L clock cycles. It then runs a sequential argmax over the per-class counts and reports the winning digit with a `done` pulse. It sits between the host or test sequencer and the network instance, and owns the network reset and the input stream-generator enable.

---
 rtl/sc_mnist_inference_ctrl_if.sv | 25 ++
 rtl/sc_mnist_inference_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sc_mnist_inference_ctrl_if.sv
// sc_mnist_inference_ctrl_if: host/network handshake bundle for the SC MNIST inference controller
interface sc_mnist_inference_ctrl_if #(
  parameter int N2 = 10,
  parameter int CW = 9,
  parameter int IW = 4
);
  logic          start;
  logic          abort;
  logic [N2-1:0] net_dout;
  logic          net_rst;
  logic          sample_en;
  logic          busy;
  logic          done;
  logic [IW-1:0] class_idx;
  logic [CW-1:0] class_score;
  logic          class_valid;
  modport master (
    output start, abort, net_dout,
    input  net_rst, sample_en, busy, done, class_idx, class_score, class_valid
  );
  modport slave (
    input  start, abort, net_dout,
    output net_rst, sample_en, busy, done, class_idx, class_score, class_valid
  );
endinterface

// File: rtl/sc_mnist_inference_ctrl.sv
// sc_mnist_inference_ctrl: sequences reset, warm-up, bitstream accumulation and argmax for the SC MNIST network
module sc_mnist_inference_ctrl #(
  parameter int N2 = 10,
  parameter int L  = 256,
  parameter int W  = 2,
  parameter int CW = 9,
  parameter int IW = 4
) (
  input logic clk,
  input logic reset,
  sc_mnist_inference_ctrl_if.slave bus
);
  localparam int LN = (L > N2) ? L : N2;
  localparam int MX = (LN > W) ? LN : W;
  localparam int TW = $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, ACCUM, ARGMAX, DONE} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] cnt_q [N2];
  logic [CW-1:0] cnt_d [N2];
  logic [IW-1:0] best_idx_q, best_idx_d, cur_idx;
  logic [CW-1:0] best_score_q, best_score_d, cur;
  logic          net_rst_q, net_rst_d;
  logic          sample_en_q, sample_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [IW-1:0] class_idx_q, class_idx_d;
  logic [CW-1:0] class_score_q, class_score_d;
  logic          class_valid_q, class_valid_d;
  logic          last;
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    cnt_d        = cnt_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    cur          = '0;
    cur_idx      = '0;
    last         = 1'b0;
    for (int k = 0; k < N2; k++)
      if (cyc_q == TW'(k)) begin
        cur     = cnt_q[k];
        cur_idx = IW'(k);
      end
    case (state_q)
      IDLE:   state_d = (bus.start && !bus.abort) ? CLEAR : IDLE;
      CLEAR: begin
        cnt_d   = '{default: '0};
        cyc_d   = '0;
        state_d = (W == 0) ? ACCUM : WARMUP;
      end
      WARMUP: begin
        last    = cyc_q == TW'(W - 1);
        cyc_d   = last ? '0 : cyc_q + 1'b1;
        state_d = last ? ACCUM : WARMUP;
      end
      ACCUM: begin
        for (int k = 0; k < N2; k++) cnt_d[k] = cnt_q[k] + CW'(bus.net_dout[k]);
        last    = cyc_q == TW'(L - 1);
        cyc_d   = last ? '0 : cyc_q + 1'b1;
        state_d = last ? ARGMAX : ACCUM;
      end
      ARGMAX: begin
        // strict compare keeps the lowest index on ties
        if (cyc_q == '0 || cur > best_score_q) begin
          best_idx_d   = cur_idx;
          best_score_d = cur;
        end
        last    = cyc_q == TW'(N2 - 1);
        cyc_d   = last ? '0 : cyc_q + 1'b1;
        state_d = last ? DONE : ARGMAX;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
    // outputs are registered from the next state so they line up with it
    net_rst_d     = state_d inside {IDLE, CLEAR, DONE};
    sample_en_d   = state_d inside {WARMUP, ACCUM};
    busy_d        = state_d != IDLE;
    done_d        = state_d == DONE;
    class_idx_d   = done_d ? best_idx_d : class_idx_q;
    class_score_d = done_d ? best_score_d : class_score_q;
    class_valid_d = done_d | (class_valid_q & !(state_q == IDLE && state_d == CLEAR));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      cnt_q         <= '{default: '0};
      best_idx_q    <= '0;
      best_score_q  <= '0;
      net_rst_q     <= 1'b1;
      sample_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      class_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      cnt_q         <= cnt_d;
      best_idx_q    <= best_idx_d;
      best_score_q  <= best_score_d;
      net_rst_q     <= net_rst_d;
      sample_en_q   <= sample_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      class_valid_q <= class_valid_d;
    end
  end
  assign bus.net_rst     = net_rst_q;
  assign bus.sample_en   = sample_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.class_idx   = class_idx_q;
  assign bus.class_score = class_score_q;
  assign bus.class_valid = class_valid_q;
endmodule
